// File: rtl/dfu_boot_supervisor.sv
// Reset, boot-timeout and warmboot supervisor for the TinyDFU bootloader tops,
// with an integrated status-LED pattern generator.
`timescale 1ns/1ps

module dfu_boot_supervisor #(
    parameter int CLK_HZ          = 12000000,
    parameter int RESET_CYCLES    = 12000,
    parameter int BOOT_TIMEOUT_MS = 3000,
    parameter int DETACH_CYCLES   = 1200,
    parameter int DEFAULT_IMAGE   = 1,
    parameter int BLINK_SHIFT     = 20,
    parameter int LED_ACTIVE_LOW  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       usb_configured,
    input  logic       dfu_detach,
    input  logic [7:0] dfu_state,
    input  logic [1:0] boot_image_req,
    output logic       core_reset,
    output logic [1:0] warmboot_s,
    output logic       warmboot_boot,
    output logic       led,
    output logic [2:0] sup_state
);

    localparam logic [63:0] BOOT_CYCLES = 64'(CLK_HZ) / 64'd1000 * 64'(BOOT_TIMEOUT_MS);
    localparam int BOOT_W = (BOOT_CYCLES > 64'd0) ? $clog2(BOOT_CYCLES + 64'd1) : 1;
    localparam int RST_W  = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int DET_W  = (DETACH_CYCLES > 0) ? $clog2(DETACH_CYCLES + 1) : 1;

    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES);
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RESET_CYCLES);
    localparam logic [DET_W-1:0]  DET_LOAD  = DET_W'(DETACH_CYCLES);
    localparam logic [1:0]        DEF_IMAGE = 2'(DEFAULT_IMAGE);
    localparam logic              LED_INV   = (LED_ACTIVE_LOW != 0);

    localparam int B = BLINK_SHIFT;
    // Bits above B+3 never reach the LED, so the free-running counter stops there.
    localparam int CNT_W = B + 4;

    typedef enum logic [2:0] {
        RESET_HOLD  = 3'd0,
        WAIT_ENUM   = 3'd1,
        STAY        = 3'd2,
        DETACH_WAIT = 3'd3,
        BOOT        = 3'd4
    } sup_state_t;

    sup_state_t        state;
    logic [RST_W-1:0]  rst_cnt;
    logic [BOOT_W-1:0] boot_cnt;
    logic [DET_W-1:0]  det_cnt;
    logic [1:0]        image;
    logic [CNT_W-1:0]  led_counter;

    logic       idle;
    logic       busy;
    logic       led_raw;
    logic [4:0] pwm_phase;
    logic [4:0] pwm;

    assign sup_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RESET_HOLD;
            rst_cnt       <= RST_LOAD;
            boot_cnt      <= BOOT_LOAD;
            det_cnt       <= DET_LOAD;
            image         <= '0;
            core_reset    <= 1'b1;
            warmboot_boot <= 1'b0;
            warmboot_s    <= '0;
        end else begin
            warmboot_boot <= (state == BOOT);
            warmboot_s    <= (state == BOOT) ? image : '0;
            case (state)
                RESET_HOLD: begin
                    if (rst_cnt == '0) begin
                        state      <= WAIT_ENUM;
                        core_reset <= 1'b0;
                    end else if (pll_locked) begin
                        rst_cnt <= rst_cnt - RST_W'(1);
                    end
                end
                WAIT_ENUM: begin
                    if (pll_locked && boot_cnt != '0)
                        boot_cnt <= boot_cnt - BOOT_W'(1);
                    if (dfu_detach) begin
                        image   <= boot_image_req;
                        det_cnt <= DET_LOAD;
                        state   <= DETACH_WAIT;
                    end else if (usb_configured) begin
                        state <= STAY;
                    end else if (boot_cnt == '0 || (pll_locked && boot_cnt == BOOT_W'(1))) begin
                        // Leave on the edge the count reaches zero: BOOT lands on the
                        // BOOT_CYCLES-th locked edge, warmboot_boot one edge later.
                        image <= DEF_IMAGE;
                        state <= BOOT;
                    end
                end
                STAY: begin
                    if (dfu_detach) begin
                        image   <= boot_image_req;
                        det_cnt <= DET_LOAD;
                        state   <= DETACH_WAIT;
                    end
                end
                DETACH_WAIT: begin
                    if (det_cnt == '0)
                        state <= BOOT;
                    else
                        det_cnt <= det_cnt - DET_W'(1);
                end
                BOOT: ;
                default: state <= RESET_HOLD;
            endcase
        end
    end

    always_comb begin
        idle      = (led_counter[B+2:B] == 3'd3) || (led_counter[B+2:B] == 3'd5);
        pwm_phase = led_counter[B+2:B-2];
        pwm       = led_counter[B+3] ? pwm_phase : (5'd31 - pwm_phase);
        busy      = (led_counter[B-3:B-7] >= pwm);
        case (dfu_state)
            8'h00:   led_raw = ~idle;
            8'h02:   led_raw = idle;
            8'h0A:   led_raw = led_counter[B-1];
            default: led_raw = busy;
        endcase
        if (state == RESET_HOLD || state == BOOT)
            led_raw = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_counter <= '0;
            led         <= LED_INV;
        end else begin
            led_counter <= led_counter + CNT_W'(1);
            led         <= led_raw ^ LED_INV;
        end
    end

endmodule

// File: tb/tb_dfu_boot_supervisor.sv
// Scoreboard bench for dfu_boot_supervisor: stimulus queues expected output
// events and LED samples, a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_dfu_boot_supervisor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked = 1'b1;
    logic       usb_configured = 1'b0;
    logic       dfu_detach = 1'b0;
    logic [7:0] dfu_state = 8'h05;
    logic [1:0] boot_image_req = 2'b00;

    logic       core_reset0, warmboot_boot0, led0;
    logic [1:0] warmboot_s0;
    logic [2:0] sup_state0;
    logic       core_reset1, warmboot_boot1, led1;
    logic [1:0] warmboot_s1;
    logic [2:0] sup_state1;

    dfu_boot_supervisor #(
        .CLK_HZ(10000), .RESET_CYCLES(4), .BOOT_TIMEOUT_MS(2), .DETACH_CYCLES(3),
        .DEFAULT_IMAGE(1), .BLINK_SHIFT(8), .LED_ACTIVE_LOW(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .usb_configured(usb_configured), .dfu_detach(dfu_detach),
        .dfu_state(dfu_state), .boot_image_req(boot_image_req),
        .core_reset(core_reset0), .warmboot_s(warmboot_s0),
        .warmboot_boot(warmboot_boot0), .led(led0), .sup_state(sup_state0)
    );

    dfu_boot_supervisor #(
        .CLK_HZ(10000), .RESET_CYCLES(4), .BOOT_TIMEOUT_MS(2), .DETACH_CYCLES(3),
        .DEFAULT_IMAGE(1), .BLINK_SHIFT(8), .LED_ACTIVE_LOW(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .usb_configured(usb_configured), .dfu_detach(dfu_detach),
        .dfu_state(dfu_state), .boot_image_req(boot_image_req),
        .core_reset(core_reset1), .warmboot_s(warmboot_s1),
        .warmboot_boot(warmboot_boot1), .led(led1), .sup_state(sup_state1)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int         edge_at;
        logic [5:0] tup;   // {sup_state, core_reset, warmboot_boot, warmboot_s}
    } ev_t;
    typedef struct {
        int   edge_at;
        logic led;         // expected led of the active-high instance
    } led_t;

    ev_t  ev_q[$];
    led_t led_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic expect_ev(input int e, input logic [2:0] st, input logic cr,
                             input logic wb, input logic [1:0] ws);
        ev_t ev;
        ev.edge_at = e;
        ev.tup = {st, cr, wb, ws};
        ev_q.push_back(ev);
    endtask

    task automatic expect_led(input int e, input logic v);
        led_t l;
        l.edge_at = e;
        l.led = v;
        led_q.push_back(l);
    endtask

    function automatic logic led_model(input int unsigned c, input logic [7:0] code);
        int unsigned hi3, ph, pwm, lo5;
        logic idle;
        hi3  = (c >> 8) & 7;
        idle = (hi3 == 3) || (hi3 == 5);
        ph   = (c >> 6) & 31;
        pwm  = ((c >> 11) & 1) != 0 ? ph : 31 - ph;
        lo5  = (c >> 1) & 31;
        case (code)
            8'h00:   return !idle;
            8'h02:   return idle;
            8'h0A:   return ((c >> 7) & 1) != 0;
            default: return lo5 >= pwm;
        endcase
    endfunction

    // Monitor: an output event is any change of the control outputs.
    logic [5:0] cur_t, cur_t1, prev_t;
    bit         prev_valid = 0;
    always @(negedge clk) begin
        cur_t  = {sup_state0, core_reset0, warmboot_boot0, warmboot_s0};
        cur_t1 = {sup_state1, core_reset1, warmboot_boot1, warmboot_s1};
        if (!prev_valid || cur_t !== prev_t) begin
            checks++;
            if (ev_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event edge=%0d got tuple=%b, required no change", edge_no, cur_t);
            end else begin
                ev_t ev;
                ev = ev_q.pop_front();
                if (ev.edge_at != edge_no || cur_t !== ev.tup || cur_t1 !== ev.tup) begin
                    failures++;
                    $display("FAIL event got edge=%0d tuple=%b/%b required edge=%0d tuple=%b",
                             edge_no, cur_t, cur_t1, ev.edge_at, ev.tup);
                end
            end
        end
        prev_t = cur_t;
        prev_valid = 1;
        while (led_q.size() > 0 && led_q[0].edge_at <= edge_no) begin
            led_t l;
            l = led_q.pop_front();
            checks++;
            if (l.edge_at != edge_no || led0 !== l.led || led1 !== ~l.led) begin
                failures++;
                $display("FAIL led edge=%0d got led0=%b led1=%b required edge=%0d led0=%b led1=%b",
                         edge_no, led0, led1, l.edge_at, l.led, ~l.led);
            end
        end
    end

    task automatic goto_edge(input int n);
        while (edge_no < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset from a non-reset state, releases it, returns release edge.
    task automatic do_reset(output int r);
        @(posedge clk);
        #2;
        expect_ev(edge_no, 3'd0, 1'b1, 1'b0, 2'b00);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        r = edge_no;
        expect_ev(r + 5, 3'd1, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog edge=%0d required completion", edge_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w, d, t;
        logic [7:0] codes [4];
        codes = '{8'h00, 8'h02, 8'h0A, 8'h05};

        // Power-on reset, then timeout into the default image
        expect_ev(1, 3'd0, 1'b1, 1'b0, 2'b00);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        r = edge_no;
        w = r + 5;
        expect_ev(w, 3'd1, 1'b0, 1'b0, 2'b00);
        expect_ev(w + 20, 3'd4, 1'b0, 1'b0, 2'b00);
        expect_ev(w + 21, 3'd4, 1'b0, 1'b1, 2'b01);
        goto_edge(w + 26);

        // Reset while in BOOT, configured host -> STAY; dropping configured is ignored
        usb_configured = 1'b1;
        do_reset(r);
        w = r + 5;
        expect_ev(w + 1, 3'd2, 1'b0, 1'b0, 2'b00);
        goto_edge(w + 4);
        usb_configured = 1'b0;
        goto_edge(w + 10);

        // Configure 10 cycles in, then detach to image 2; a second pulse is ignored
        do_reset(r);
        w = r + 5;
        goto_edge(w + 9);
        usb_configured = 1'b1;
        expect_ev(w + 10, 3'd2, 1'b0, 1'b0, 2'b00);
        goto_edge(w + 14);
        dfu_detach = 1'b1;
        boot_image_req = 2'b10;
        d = w + 15;
        expect_ev(d, 3'd3, 1'b0, 1'b0, 2'b00);
        expect_ev(d + 4, 3'd4, 1'b0, 1'b0, 2'b00);
        expect_ev(d + 5, 3'd4, 1'b0, 1'b1, 2'b10);
        goto_edge(d);
        dfu_detach = 1'b0;
        goto_edge(d + 1);
        dfu_detach = 1'b1;
        boot_image_req = 2'b11;
        goto_edge(d + 2);
        dfu_detach = 1'b0;
        goto_edge(d + 10);

        // Lock lost for 7 cycles in WAIT_ENUM delays the timeout by 7
        usb_configured = 1'b0;
        do_reset(r);
        w = r + 5;
        expect_ev(w + 27, 3'd4, 1'b0, 1'b0, 2'b00);
        expect_ev(w + 28, 3'd4, 1'b0, 1'b1, 2'b01);
        goto_edge(w + 5);
        pll_locked = 1'b0;
        goto_edge(w + 12);
        pll_locked = 1'b1;
        goto_edge(w + 32);

        // Same, but configured arrives on the timeout cycle -> STAY wins
        do_reset(r);
        w = r + 5;
        goto_edge(w + 5);
        pll_locked = 1'b0;
        goto_edge(w + 12);
        pll_locked = 1'b1;
        goto_edge(w + 26);
        usb_configured = 1'b1;
        expect_ev(w + 27, 3'd2, 1'b0, 1'b0, 2'b00);
        goto_edge(w + 40);

        // Detach and configured in the same WAIT_ENUM cycle -> detach wins
        usb_configured = 1'b0;
        do_reset(r);
        w = r + 5;
        goto_edge(w + 3);
        usb_configured = 1'b1;
        dfu_detach = 1'b1;
        boot_image_req = 2'b11;
        expect_ev(w + 4, 3'd3, 1'b0, 1'b0, 2'b00);
        expect_ev(w + 8, 3'd4, 1'b0, 1'b0, 2'b00);
        expect_ev(w + 9, 3'd4, 1'b0, 1'b1, 2'b11);
        goto_edge(w + 4);
        dfu_detach = 1'b0;
        goto_edge(w + 12);

        // LED: gated in RESET_HOLD, then pattern sweep in STAY
        dfu_state = 8'h00;
        do_reset(r);
        w = r + 5;
        expect_ev(w + 1, 3'd2, 1'b0, 1'b0, 2'b00);
        for (int j = 0; j <= 5; j++) expect_led(r + j, 1'b0);
        t = r + 10;
        for (int unsigned i = 0; i < 4; i++) begin
            goto_edge(t);
            dfu_state = codes[i];
            for (int j = t + 1; j <= t + 2048; j += 11)
                expect_led(j, led_model(int'(j - r - 1), codes[i]));
            t = t + 2048;
        end
        goto_edge(t + 5);

        checks++;
        if (ev_q.size() != 0 || led_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got events=%0d leds=%0d required 0 0",
                     ev_q.size(), led_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
